dcache_responder: RTL and testbench

Data-memory responder for the five-stage RV32I core: serves the core's M-stage load/store port from a direct-mapped, write-through, no-write-allocate cache and drives the core's `waiting` stall. It is the far end of the core's data-memory interface. It returns load words registered so they arrive at the core's W-stage load-data input one edge after a hit. On a miss it refills a line from backing memory over a req/ack handshake.

---
 rtl/dcache_responder.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_dcache_responder.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_responder.sv
// ---------------------------------------------------------------------------
// dcache_responder
//
// Data-memory responder for the five-stage RV32I core. It serves the core's
// M-stage load/store port from a direct-mapped, write-through,
// no-write-allocate cache and drives the core's `waiting` stall. Load words
// are registered so they reach the core's W-stage load-data input one edge
// after a hit. A load miss refills the whole line from backing memory, one
// word per req/ack beat. Every store is written through as a single beat and
// is merged into the cache only when its line is already present.
//
// Optional feature: define DCACHE_STATS_EN to add the hit_cnt / miss_cnt
// statistics ports and counters. Without it, the ports and counters are absent
// and the behaviour is otherwise identical.
//
// Parameters
//   SETS        number of cache lines (power of 2, >= 2)
//   LINE_WORDS  32-bit words per line (power of 2, >= 2)
//
// Ports
//   clk, rst    rising-edge clock, synchronous active-high reset
//   cpu_req     valid M-stage access this cycle
//   cpu_addr    byte address (bits [1:0] ignored)
//   cpu_w_en    byte write strobes; nonzero = store, zero = load
//   cpu_wdata   lane-aligned store data
//   cpu_rdata   registered load word to the core's W stage
//   waiting     combinational stall; the core holds cpu_* stable while high
//   mem_req     backing-memory request, held until mem_ack
//   mem_we      1 = write beat, 0 = read beat
//   mem_addr    word-aligned beat address
//   mem_wdata   write-beat data
//   mem_wstrb   write-beat byte strobes
//   mem_rdata   read data, valid with mem_ack
//   mem_ack     one-cycle completion pulse for the current beat
//   hit_cnt     (DCACHE_STATS_EN) number of IDLE load hits
//   miss_cnt    (DCACHE_STATS_EN) number of refills started
// ---------------------------------------------------------------------------
module dcache_responder #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_w_en,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        waiting,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Registers and storage
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [OFF_W-1:0]   beat_q, beat_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [3:0]         mem_wstrb_q, mem_wstrb_d;

    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS][LINE_WORDS];

    // ------------------------------------------------------------------
    // Address decode and lookup
    // ------------------------------------------------------------------
    logic [OFF_W-1:0]   off;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               is_store;
    logic               hit;
    logic               ack;
    logic               last_beat;
    logic               unused_addr_bits;

    assign off       = cpu_addr[OFF_W+1:2];
    assign idx       = cpu_addr[OFF_W+IDX_W+1:OFF_W+2];
    assign tag       = cpu_addr[31:OFF_W+IDX_W+2];
    assign is_store  = |cpu_w_en;
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    // A stray ack arriving while no beat is outstanding (for instance after a
    // reset aborted a transfer) must not advance anything.
    assign ack       = mem_ack && mem_req_q;
    assign last_beat = (beat_q == OFF_W'(LINE_WORDS - 1));

    assign unused_addr_bits = ^cpu_addr[1:0];

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    logic waiting_c;
    logic fill_we;
    logic fill_last;
    logic merge_we;
    logic hit_evt;
    logic miss_evt;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        waiting_c   = 1'b0;
        fill_we     = 1'b0;
        fill_last   = 1'b0;
        merge_we    = 1'b0;
        hit_evt     = 1'b0;
        miss_evt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (is_store) begin
                        // Every store goes through to memory, hit or miss.
                        waiting_c   = 1'b1;
                        state_d     = WRITE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {cpu_addr[31:2], 2'b00};
                        mem_wdata_d = cpu_wdata;
                        mem_wstrb_d = cpu_w_en;
                    end else if (hit) begin
                        cpu_rdata_d = data_q[idx][off];
                        hit_evt     = 1'b1;
                    end else begin
                        // Refill the whole line starting at word 0; the held
                        // load then hits once the line is valid.
                        waiting_c   = 1'b1;
                        state_d     = REFILL;
                        beat_d      = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {cpu_addr[31:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
                        miss_evt    = 1'b1;
                    end
                end
            end

            REFILL: begin
                waiting_c = 1'b1;
                if (ack) begin
                    fill_we = 1'b1;
                    if (last_beat) begin
                        fill_last = 1'b1;
                        state_d   = IDLE;
                        mem_req_d = 1'b0;
                    end else begin
                        // mem_req stays high; the next beat's address is
                        // presented from the following cycle.
                        beat_d     = beat_q + 1'b1;
                        mem_addr_d = {cpu_addr[31:OFF_W+2], beat_d, 2'b00};
                    end
                end
            end

            WRITE: begin
                waiting_c = 1'b1;
                if (ack) begin
                    // No allocation on a store miss: only a resident line is
                    // updated.
                    merge_we  = hit;
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                end
            end

            DONE: begin
                // One stall-free cycle so the core retires the store.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign waiting = waiting_c && !rst;

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            // A line only becomes valid once its last beat has landed, so a
            // reset part-way through a refill leaves it invalid.
            if (fill_last) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag and data arrays (not reset; qualified by valid_q)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_we) begin
                data_q[idx][beat_q] <= mem_rdata;
            end
            if (fill_last) begin
                tag_q[idx] <= tag;
            end
            if (merge_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (cpu_w_en[b]) begin
                        data_q[idx][off][8*b +: 8] <= cpu_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// ---------------------------------------------------------------------------
// tb_dcache_responder
//
// Directed and randomized bench for dcache_responder. A backing-memory
// responder with random ack latency serves the DUT's mem_* port and logs
// every accepted beat. A reference model keeps per-set valid/tag state and a
// word-addressed backing memory. From these it predicts, for each access,
// hit or miss, the exact beat sequence, the returned load word, and the
// statistics counts (when DCACHE_STATS_EN is defined).
// ---------------------------------------------------------------------------
module tb_dcache_responder;

    localparam int NS   = 16;
    localparam int LW   = 4;
    localparam int OFFB = $clog2(LW) + 2;
    localparam int IDXB = $clog2(NS);

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_w_en;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        waiting;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    dcache_responder #(.SETS(NS), .LINE_WORDS(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_w_en  (cpu_w_en),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .waiting   (waiting),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Backing memory (word address -> data) and accepted-beat log.
    logic [31:0] bmem [int unsigned];
    logic        log_we   [$];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];
    logic [3:0]  log_strb [$];

    int acks_given = 0;
    int ack_limit  = 32'h7fff_ffff;
    int stray_req  = 0;
    int stray_done = 0;
    int lat        = 0;

    // Reference cache state.
    bit          ref_valid [NS];
    logic [31:0] ref_tag   [NS];
    logic [31:0] exp_hits;
    logic [31:0] exp_miss;

    function automatic logic [31:0] rd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (bmem.exists(k)) return bmem[k];
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Backing-memory responder: random 0..2 cycle latency per beat.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (stray_req != stray_done) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hDEAD_0000;
            stray_done++;
        end else if (mem_req === 1'b1 && acks_given < ack_limit) begin
            if (lat == 0) begin
                mem_ack = 1'b1;
                log_we.push_back(mem_we);
                log_addr.push_back(mem_addr);
                log_data.push_back(mem_wdata);
                log_strb.push_back(mem_wstrb);
                if (mem_we) bmem[mem_addr >> 2] = merge(rd(mem_addr), mem_wdata, mem_wstrb);
                else mem_rdata = rd(mem_addr);
                acks_given++;
                lat = $urandom_range(0, 2);
            end else begin
                lat--;
            end
        end
    end

    // One core access; returns after the retiring edge.
    task automatic access(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
        int          s;
        logic [31:0] t;
        bit          exp_hit;
        bit          first_wait;
        int          base;
        int          cyc;
        logic [31:0] prev_rdata;
        logic [31:0] exp_mem;
        logic [31:0] lb;
        s       = int'((a >> OFFB) % NS);
        t       = a >> (OFFB + IDXB);
        exp_hit = ref_valid[s] && ref_tag[s] == t;
        base    = log_addr.size();
        lb      = a & ~32'(LW * 4 - 1);
        exp_mem = merge(rd(a), wd, we);
        @(negedge clk);
        prev_rdata = cpu_rdata;
        cpu_req = 1'b1; cpu_addr = a; cpu_w_en = we; cpu_wdata = wd;
        #1;
        first_wait = waiting;
        cyc = 0;
        while (waiting && cyc < 200) begin
            @(negedge clk); #1; cyc++;
        end
        chk("stall_bound", 32'(cyc < 200), 32'd1);
        @(posedge clk); #1;
        if (we == 4'b0) begin
            chk("load_stall", 32'(first_wait), 32'(!exp_hit));
            chk("load_beats", 32'(log_addr.size() - base), exp_hit ? 32'd0 : 32'(LW));
            if (!exp_hit)
                for (int i = 0; i < LW; i++)
                    if (base + i < log_addr.size()) begin
                        chk("refill_addr", log_addr[base+i], lb + 32'(4 * i));
                        chk("refill_we", 32'(log_we[base+i]), 32'd0);
                    end
            chk("load_data", cpu_rdata, rd(a));
            ref_valid[s] = 1'b1;
            ref_tag[s]   = t;
            exp_hits++;
            if (!exp_hit) exp_miss++;
        end else begin
            chk("store_stall", 32'(first_wait), 32'd1);
            chk("store_beats", 32'(log_addr.size() - base), 32'd1);
            if (log_addr.size() > base) begin
                chk("store_addr", log_addr[base], a & ~32'd3);
                chk("store_we", 32'(log_we[base]), 32'd1);
                chk("store_wdata", log_data[base], wd);
                chk("store_wstrb", 32'(log_strb[base]), 32'(we));
            end
            chk("store_mem", rd(a), exp_mem);
            chk("store_rdata_hold", cpu_rdata, prev_rdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] prev;
        int          cyc;
        int          target;

        for (int i = 0; i < NS; i++) begin ref_valid[i] = 1'b0; ref_tag[i] = '0; end
        exp_hits = '0; exp_miss = '0;
        bmem[32'h100 >> 2] = 32'h0000_00A0;
        bmem[32'h104 >> 2] = 32'h0000_00A1;
        bmem[32'h108 >> 2] = 32'h0000_00A2;
        bmem[32'h10C >> 2] = 32'h0000_00A3;

        // Reset: waiting forced low even with a pending store on the port.
        rst = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h104; cpu_w_en = 4'hF; cpu_wdata = '1;
        @(negedge clk); #1;
        chk("rst_waiting", 32'(waiting), 32'd0);
        @(negedge clk);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
`ifdef DCACHE_STATS_EN
        chk("rst_hit_cnt", hit_cnt, 32'd0);
        chk("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        rst = 1'b0; cpu_req = 1'b0; cpu_w_en = 4'h0;

        // Cold miss on 0x104, then a hit on 0x108.
        access(32'h104, 4'h0, 32'h0);
        chk("cold_rdata", cpu_rdata, 32'h0000_00A1);
        access(32'h108, 4'h0, 32'h0);
        chk("hit_rdata", cpu_rdata, 32'h0000_00A2);

        // Store hit then reload from cache.
        access(32'h104, 4'b0011, 32'h0000_BEEF);
        access(32'h104, 4'h0, 32'h0);
        chk("store_hit_reload", cpu_rdata, 32'h0000_BEEF);

        // Store miss does not allocate.
        access(32'h2000, 4'b1111, 32'h1357_9BDF);
        access(32'h2000, 4'h0, 32'h0);
        chk("store_miss_reload", cpu_rdata, 32'h1357_9BDF);

        // Conflict within one set.
        access(32'h100, 4'h0, 32'h0);
        access(32'h100 + NS * LW * 4, 4'h0, 32'h0);
        access(32'h100, 4'h0, 32'h0);

        // Idle cycle: no stall, rdata holds.
        @(negedge clk); cpu_req = 1'b0; prev = cpu_rdata; #1;
        chk("idle_waiting", 32'(waiting), 32'd0);
        @(posedge clk); #1;
        chk("idle_rdata_hold", cpu_rdata, prev);

        // Reset after the second refill ack of a miss on 0x300.
        target = acks_given + 2;
        ack_limit = target;
        @(negedge clk); cpu_req = 1'b1; cpu_addr = 32'h300; cpu_w_en = 4'h0;
        cyc = 0;
        while (acks_given < target && cyc < 100) begin @(negedge clk); cyc++; end
        chk("rst_wait_bound", 32'(cyc < 100), 32'd1);
        @(negedge clk);
        rst = 1'b1; #1;
        chk("midrst_waiting", 32'(waiting), 32'd0);
        @(posedge clk); #1;
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        for (int i = 0; i < NS; i++) ref_valid[i] = 1'b0;
        exp_hits = '0; exp_miss = '0;
        @(negedge clk); rst = 1'b0; cpu_req = 1'b0;
        ack_limit = 32'h7fff_ffff;
        stray_req++;
        @(negedge clk); @(negedge clk); #1;
        chk("stray_mem_req", 32'(mem_req), 32'd0);
        chk("stray_waiting", 32'(waiting), 32'd0);
        access(32'h300, 4'h0, 32'h0);

        // Randomized traffic over four tags that alias across all sets.
        for (int k = 0; k < 80; k++) begin
            a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 63)) << 2);
            we = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'h0;
            access(a, we, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk); cpu_req = 1'b0; prev = cpu_rdata;
                @(posedge clk); #1;
                chk("rand_idle_hold", cpu_rdata, prev);
            end
        end

`ifdef DCACHE_STATS_EN
        chk("hit_cnt", hit_cnt, exp_hits);
        chk("miss_cnt", miss_cnt, exp_miss);
        @(negedge clk); cpu_req = 1'b0;
        dut.miss_cnt_q <= 32'hFFFF_FFFF;
        exp_miss = 32'hFFFF_FFFF;
        access(32'h7000, 4'h0, 32'h0);
        chk("miss_cnt_wrap", miss_cnt, exp_miss);
        chk("miss_cnt_zero", miss_cnt, 32'd0);
`endif

        @(negedge clk); cpu_req = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
